// File: rtl/dmem_copy_master.sv
// Data-memory copy engine: sequentially copies len words from src_base to dst_base (read, then write, per word).
// Optional running checksum of copied words is enabled by defining DMEM_COPY_CHECKSUM_EN.
module dmem_copy_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;

  // End addresses are one bit wider so a region ending exactly at MEM_DEPTH does not wrap.
  logic [ADDR_W:0] src_end, dst_end;
  logic            range_bad;

  assign src_end   = {1'b0, src_base} + {1'b0, len};
  assign dst_end   = {1'b0, dst_base} + {1'b0, len};
  assign range_bad = (src_end > DEPTH_EXT) || (dst_end > DEPTH_EXT);

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    address     = '0;
    writedata   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            state_d = S_ERR;
          end else if (len == '0) begin
            state_d = S_DONE;
          end else begin
            rd_ptr_d    = src_base;
            wr_ptr_d    = dst_base;
            remaining_d = len;
            state_d     = S_READ;
          end
        end
      end
      S_READ: begin
        busy     = 1'b1;
        memread  = 1'b1;
        address  = rd_ptr_q;
        data_d   = readdata;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        memwrite    = 1'b1;
        address     = wr_ptr_q;
        writedata   = data_q;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == ADDR_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Cleared by any start that passes the range check, including len==0; a rejected start keeps the old sum.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && start && !range_bad) checksum_d = '0;
    else if (state_q == S_WRITE)                  checksum_d = checksum_q + data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/dmem_copy_master.md
# dmem_copy_master

Bus-initiator block that drives the data-memory port (memread / memwrite / address / writedata / readdata) to copy a contiguous block of words from a source region to a destination region. It sits beside the single-cycle datapath as a small copy engine that owns the data-memory port while busy. The datapath must not drive the memory during that time. Word transfers are strictly sequential: one read cycle, then one write cycle per word.

## Interface
- ADDR_W, 8, memory word-address width
- DATA_W, 32, memory data width
- MEM_DEPTH, 64, number of addressable words; the legal address range is 0..MEM_DEPTH-1

- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a copy; sampled only in IDLE
- src_base  input  ADDR_W  first source word address
- dst_base  input  ADDR_W  first destination word address
- len  input  ADDR_W  number of words to copy (0..MEM_DEPTH)
- busy  output  1  high from the cycle after an accepted start until the cycle before IDLE
- done  output  1  one-cycle pulse when the copy completes
- err  output  1  one-cycle pulse when a start is rejected by the range check
- checksum  output  DATA_W  sum of copied words (see Configuration)
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- address  output  ADDR_W  memory word address
- writedata  output  DATA_W  memory write data
- readdata  input  DATA_W  memory read data; valid combinationally in the same cycle memread and address are presented

## Operation
- FSM states:
  - IDLE: accepts start.
  - READ: issues a read.
  - WRITE: issues a write.
  - DONE: pulses done.
  - ERR: pulses err.
- IDLE transitions on start=1:
  - If src_base+len > MEM_DEPTH or dst_base+len > MEM_DEPTH, go to ERR. Sums are computed at ADDR_W+1 bits, with no wrap.
  - Else if len==0, go to DONE.
  - Else latch src_base, dst_base and len into rd_ptr, wr_ptr and remaining, then go to READ.
- READ: drive address=rd_ptr and memread=1. At the clock edge, capture readdata into the data register, increment rd_ptr, and go to WRITE.
- WRITE: drive address=wr_ptr, memwrite=1 and writedata=data register. At the clock edge, increment wr_ptr and decrement remaining. Go to DONE if remaining was 1; otherwise go to READ.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE. No memory access occurs.
- start is ignored in every state other than IDLE.
- Inputs are sampled only at acceptance; later changes have no effect on a copy in progress.
- Overlapping regions are copied forward, word by word. Each read observes all earlier writes, so dst=src+1 replicates mem[src].
- memread and memwrite are never both high. Both are low in IDLE, DONE and ERR.

## Timing
- All outputs are registered, or decoded from registered state only.
- Reset values:
  - State is IDLE.
  - busy, done, err, memread and memwrite are 0.
  - address, writedata and checksum are 0.
- Latency:
  - Accepted start with len=N>0: done is asserted at cycle 2N+1 after the start edge.
  - len==0: done at cycle 1.
  - Range error: err at cycle 1.
- busy=1 in READ and WRITE only.
- In IDLE, DONE and ERR, address and writedata hold 0.
- Reset mid-operation forces IDLE at the next edge, and memwrite drops that same edge. Words already written stay written. No done or err pulse is produced.
- A start presented in the same cycle as DONE or ERR is ignored. A new start is accepted in the following IDLE cycle.

## Configuration
- DMEM_COPY_CHECKSUM_EN defined:
  - checksum is cleared on an accepted start.
  - Each WRITE cycle adds writedata modulo 2^DATA_W.
  - The value is stable and valid from the done pulse until the next accepted start. It is not cleared on err.
- DMEM_COPY_CHECKSUM_EN undefined: the checksum port exists but is tied to 0, and no adder is instantiated.

## Test plan
All scenarios use a bench memory with mem[i]=i*10 and DMEM_COPY_CHECKSUM_EN defined.
- Basic copy: src=0, dst=32, len=4 → mem[32..35]=0,10,20,30; done at cycle 9; checksum=60; busy high for cycles 1..8.
- Zero length: len=0 → done at cycle 1; memread and memwrite never asserted; checksum=0.
- Range error: src=60, dst=0, len=5 → err at cycle 1; no memory strobes; busy stays 0; memory unchanged.
- Overlapping copy: src=10, dst=11, len=3 → mem[11..13]=100,100,100; checksum=300.
- Reset mid-copy: src=0, dst=40, len=4 with reset during the second WRITE → mem[40]=0 and mem[41]=10; mem[42..43]=420,430 unchanged; outputs at reset values the next cycle; no done pulse.
- start while busy: pulse start with different src, dst and len during a len=4 copy → the pulse is ignored and the original copy completes exactly as in the basic-copy scenario.
